uart_core: RTL and testbench

- 8N1 UART transceiver on the CPU's UART IO port (address bit 12 data, bit 13 status).
- Consumes the CPU-side write strobe and byte, produces the receive-valid flag and byte.
- Each direction has a small FIFO. The status word reports TX as permanently ready, so this block must absorb CPU write bursts itself.

---
 rtl/uart_core.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_uart_core.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core.sv
// 8N1 UART transceiver with independent TX and RX byte FIFOs.
// CPU writes are absorbed by the TX FIFO; received bytes are presented show-ahead.
module uart_core #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned FIFO_LOG2    = 4
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       uart_wr,
    input  logic [7:0] uart_w,
    input  logic       uart_rd,
    output logic       uart_valid,
    output logic [7:0] uart_data,
    input  logic       err_clr,
    output logic       tx_busy,
    output logic       tx_overflow,
    output logic       rx_overrun,
    output logic       rx_frame_err,
    input  logic       rx,
    output logic       tx
);

    localparam int unsigned Depth = 1 << FIFO_LOG2;
    localparam int unsigned PtrW  = FIFO_LOG2 + 1;
    localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_e;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]      txf_mem_q [Depth];
    logic [PtrW-1:0] txf_wptr_q, txf_wptr_d;
    logic [PtrW-1:0] txf_rptr_q, txf_rptr_d;
    logic            txf_full, txf_empty, txf_push, txf_pop;
    logic [7:0]      txf_head;

    assign txf_empty = (txf_wptr_q == txf_rptr_q);
    assign txf_full  = (txf_wptr_q[PtrW-1] != txf_rptr_q[PtrW-1]) &&
                       (txf_wptr_q[PtrW-2:0] == txf_rptr_q[PtrW-2:0]);
    assign txf_push  = uart_wr && !txf_full;
    assign txf_head  = txf_mem_q[txf_rptr_q[PtrW-2:0]];
    assign txf_wptr_d = txf_push ? txf_wptr_q + 1'b1 : txf_wptr_q;
    assign txf_rptr_d = txf_pop  ? txf_rptr_q + 1'b1 : txf_rptr_q;

    always_ff @(posedge clk) begin
        if (txf_push) begin
            txf_mem_q[txf_wptr_q[PtrW-2:0]] <= uart_w;
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    uart_state_e     tx_state_q, tx_state_d;
    logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            tx_q, tx_d;
    logic            tx_cnt_end;

    assign tx_cnt_end = (tx_cnt_q == '0);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = 1'b1;
        txf_pop    = 1'b0;
        unique case (tx_state_q)
            StIdle: begin
                if (!txf_empty) begin
                    txf_pop    = 1'b1;
                    tx_shift_d = txf_head;
                    tx_cnt_d   = CntMax;
                    tx_state_d = StStart;
                end
            end
            StStart: begin
                tx_d = 1'b0;
                if (tx_cnt_end) begin
                    tx_cnt_d   = CntMax;
                    tx_bit_d   = 3'd0;
                    tx_state_d = StData;
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            StData: begin
                tx_d = tx_shift_q[0];
                if (tx_cnt_end) begin
                    tx_cnt_d   = CntMax;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = StStop;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            StStop: begin
                if (tx_cnt_end) begin
                    // Chain straight into the next start bit to avoid an idle gap.
                    if (!txf_empty) begin
                        txf_pop    = 1'b1;
                        tx_shift_d = txf_head;
                        tx_cnt_d   = CntMax;
                        tx_state_d = StStart;
                    end else begin
                        tx_state_d = StIdle;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            default: tx_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_state_q <= StIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tx_q       <= 1'b1;
            txf_wptr_q <= '0;
            txf_rptr_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            txf_wptr_q <= txf_wptr_d;
            txf_rptr_q <= txf_rptr_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = !txf_empty || (tx_state_q != StIdle);

    // ------------------------------------------------------------------
    // RX synchronizer and FSM
    // ------------------------------------------------------------------
    logic rx_meta_q, rx_sync_q, rx_prev_q;
    logic rx_fall;

    assign rx_fall = rx_prev_q && !rx_sync_q;

    uart_state_e     rx_state_q, rx_state_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_cnt_end;
    logic            rx_push_req, rx_frame_evt;

    assign rx_cnt_end = (rx_cnt_q == '0);

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_push_req  = 1'b0;
        rx_frame_evt = 1'b0;
        unique case (rx_state_q)
            StIdle: begin
                if (rx_fall) begin
                    rx_cnt_d   = CntHalf;
                    rx_state_d = StStart;
                end
            end
            StStart: begin
                if (rx_cnt_end) begin
                    if (!rx_sync_q) begin
                        rx_cnt_d   = CntMax;
                        rx_bit_d   = 3'd0;
                        rx_state_d = StData;
                    end else begin
                        rx_state_d = StIdle;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            StData: begin
                if (rx_cnt_end) begin
                    rx_cnt_d   = CntMax;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = StStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            StStop: begin
                if (rx_cnt_end) begin
                    rx_push_req  = rx_sync_q;
                    rx_frame_evt = !rx_sync_q;
                    rx_state_d   = StIdle;
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            default: rx_state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [7:0]      rxf_mem_q [Depth];
    logic [PtrW-1:0] rxf_wptr_q, rxf_wptr_d;
    logic [PtrW-1:0] rxf_rptr_q, rxf_rptr_d;
    logic            rxf_full, rxf_empty, rxf_push, rxf_pop, rx_overrun_evt;

    assign rxf_empty = (rxf_wptr_q == rxf_rptr_q);
    assign rxf_full  = (rxf_wptr_q[PtrW-1] != rxf_rptr_q[PtrW-1]) &&
                       (rxf_wptr_q[PtrW-2:0] == rxf_rptr_q[PtrW-2:0]);
    assign rxf_pop   = uart_rd && !rxf_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign rxf_push       = rx_push_req && (!rxf_full || rxf_pop);
    assign rx_overrun_evt = rx_push_req && rxf_full && !rxf_pop;
    assign rxf_wptr_d = rxf_push ? rxf_wptr_q + 1'b1 : rxf_wptr_q;
    assign rxf_rptr_d = rxf_pop  ? rxf_rptr_q + 1'b1 : rxf_rptr_q;

    always_ff @(posedge clk) begin
        if (rxf_push) begin
            rxf_mem_q[rxf_wptr_q[PtrW-2:0]] <= rx_shift_d;
        end
    end

    assign uart_valid = !rxf_empty;
    assign uart_data  = rxf_empty ? 8'h00 : rxf_mem_q[rxf_rptr_q[PtrW-2:0]];

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= StIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rxf_wptr_q <= '0;
            rxf_rptr_q <= '0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rxf_wptr_q <= rxf_wptr_d;
            rxf_rptr_q <= rxf_rptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags; a same-cycle event wins over err_clr.
    // ------------------------------------------------------------------
    logic tx_ovf_q, tx_ovf_d;
    logic rx_ovr_q, rx_ovr_d;
    logic rx_ferr_q, rx_ferr_d;

    assign tx_ovf_d  = (tx_ovf_q  && !err_clr) || (uart_wr && txf_full);
    assign rx_ovr_d  = (rx_ovr_q  && !err_clr) || rx_overrun_evt;
    assign rx_ferr_d = (rx_ferr_q && !err_clr) || rx_frame_evt;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_ovf_q  <= 1'b0;
            rx_ovr_q  <= 1'b0;
            rx_ferr_q <= 1'b0;
        end else begin
            tx_ovf_q  <= tx_ovf_d;
            rx_ovr_q  <= rx_ovr_d;
            rx_ferr_q <= rx_ferr_d;
        end
    end

    assign tx_overflow  = tx_ovf_q;
    assign rx_overrun   = rx_ovr_q;
    assign rx_frame_err = rx_ferr_q;

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core at CLKS_PER_BIT=4, FIFO_LOG2=2.
// A line monitor decodes tx frames so TX data and frame spacing can be compared.
module tb_uart_core;

    localparam int unsigned Cpb = 4;

    logic       clk = 1'b0;
    logic       resetq = 1'b0;
    logic       uart_wr = 1'b0;
    logic [7:0] uart_w = 8'h00;
    logic       uart_rd = 1'b0;
    logic       uart_valid;
    logic [7:0] uart_data;
    logic       err_clr = 1'b0;
    logic       tx_busy, tx_overflow, rx_overrun, rx_frame_err;
    logic       tx;
    logic       rx_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic       rx_line;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;

    assign rx_line = loop_en ? tx : rx_drv;

    uart_core #(
        .CLKS_PER_BIT (Cpb),
        .FIFO_LOG2    (2)
    ) dut (
        .clk          (clk),
        .resetq       (resetq),
        .uart_wr      (uart_wr),
        .uart_w       (uart_w),
        .uart_rd      (uart_rd),
        .uart_valid   (uart_valid),
        .uart_data    (uart_data),
        .err_clr      (err_clr),
        .tx_busy      (tx_busy),
        .tx_overflow  (tx_overflow),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err),
        .rx           (rx_line),
        .tx           (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // tx line decoder: start detected on a negedge, bits sampled mid-bit
    logic [7:0]  mon_data [$];
    int unsigned mon_start [$];
    bit          mon_ok [$];
    logic [7:0]  tm_b;
    int unsigned tm_t0;
    bit          tm_ok, tm_rst;

    initial begin : tx_mon
        forever begin
            @(negedge clk);
            if (resetq && tx === 1'b0) begin
                tm_t0 = cyc;
                tm_ok = 1'b1;
                tm_rst = 1'b0;
                tm_b = 8'h00;
                repeat (2) @(negedge clk);
                if (tx !== 1'b0) tm_ok = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    repeat (Cpb) @(negedge clk);
                    tm_b[k] = tx;
                    if (!resetq) tm_rst = 1'b1;
                end
                repeat (Cpb) @(negedge clk);
                if (tx !== 1'b1) tm_ok = 1'b0;
                if (!resetq) tm_rst = 1'b1;
                if (!tm_rst) begin
                    mon_data.push_back(tm_b);
                    mon_start.push_back(tm_t0);
                    mon_ok.push_back(tm_ok);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic write_tx(input logic [7:0] b);
        uart_wr = 1'b1;
        uart_w  = b;
        tick();
        uart_wr = 1'b0;
    endtask

    task automatic read_rx();
        uart_rd = 1'b1;
        tick();
        uart_rd = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        rx_drv = 1'b0;
        wait_cycles(Cpb);
        for (int k = 0; k < 8; k++) begin
            rx_drv = b[k];
            wait_cycles(Cpb);
        end
        rx_drv = stop;
        wait_cycles(Cpb);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (uart_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(uart_valid), 32'd1);
    endtask

    task automatic clear_mon();
        mon_data.delete();
        mon_start.delete();
        mon_ok.delete();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        logic [7:0] exp_q [4];
        logic [7:0] lb_q [3];
        int n;
        int lows;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_valid", 32'(uart_valid), 32'd0);
        check("rst_data", 32'(uart_data), 32'h00);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_flags", 32'({tx_overflow, rx_overrun, rx_frame_err}), 32'd0);
        @(posedge clk);
        #1 resetq = 1'b1;
        wait_cycles(3);

        // Single TX: 0xA5, start bit on the 2nd edge after the write edge
        clear_mon();
        write_tx(8'hA5);
        @(negedge clk);
        check("tx_lat0", 32'(tx), 32'd1);
        check("tx_busy_early", 32'(tx_busy), 32'd1);
        @(negedge clk);
        check("tx_lat1", 32'(tx), 32'd1);
        @(negedge clk);
        check("tx_lat2_start", 32'(tx), 32'd0);
        repeat (20) @(negedge clk);
        check("tx_busy_mid", 32'(tx_busy), 32'd1);
        repeat (20) @(negedge clk);
        check("tx_idle_after", 32'(tx), 32'd1);
        check("tx_busy_after", 32'(tx_busy), 32'd0);
        check("tx_a5_count", mon_data.size(), 32'd1);
        check("tx_a5_data", (mon_data.size() > 0) ? 32'(mon_data[0]) : 32'hdead, 32'hA5);
        check("tx_a5_frame", (mon_ok.size() > 0) ? 32'(mon_ok[0]) : 32'hdead, 32'd1);

        // TX burst: 6 writes, 5 fit, frames back to back
        clear_mon();
        for (int i = 1; i <= 6; i++) begin
            uart_wr = 1'b1;
            uart_w  = 8'(i);
            tick();
            if (i == 5) check("ovf_before", 32'(tx_overflow), 32'd0);
        end
        uart_wr = 1'b0;
        check("ovf_set", 32'(tx_overflow), 32'd1);
        n = 0;
        while (mon_data.size() < 5 && n < 400) begin
            tick();
            n++;
        end
        wait_cycles(100);
        check("burst_count", mon_data.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check("burst_data", (i < mon_data.size()) ? 32'(mon_data[i]) : 32'hdead, 32'(i + 1));
            check("burst_frame", (i < mon_ok.size()) ? 32'(mon_ok[i]) : 32'hdead, 32'd1);
            if (i > 0) begin
                check("burst_gap", (i < mon_start.size()) ?
                      (mon_start[i] - mon_start[i-1]) : 32'hdead, 32'd40);
            end
        end
        check("burst_busy_end", 32'(tx_busy), 32'd0);
        pulse_clr();
        check("ovf_clr", 32'(tx_overflow), 32'd0);

        // RX byte
        send_rx(8'h3C, 1'b1);
        wait_valid("rx3c_valid");
        check("rx3c_data", 32'(uart_data), 32'h3C);
        read_rx();
        @(negedge clk);
        check("rx3c_pop_valid", 32'(uart_valid), 32'd0);
        check("rx3c_pop_data", 32'(uart_data), 32'h00);

        // 1-cycle glitch
        rx_drv = 1'b0;
        tick();
        rx_drv = 1'b1;
        wait_cycles(60);
        check("glitch_valid", 32'(uart_valid), 32'd0);
        check("glitch_flags", 32'({rx_overrun, rx_frame_err}), 32'd0);

        // Stop bit low, line held low afterwards
        send_rx(8'hA5, 1'b0);
        wait_cycles(50);
        check("ferr_set", 32'(rx_frame_err), 32'd1);
        check("ferr_nopush", 32'(uart_valid), 32'd0);
        rx_drv = 1'b1;
        wait_cycles(60);
        check("ferr_no_more", 32'(uart_valid), 32'd0);
        pulse_clr();
        check("ferr_clr", 32'(rx_frame_err), 32'd0);

        // Overrun: 5 frames, 4 stored
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        send_rx(8'h33, 1'b1);
        send_rx(8'h44, 1'b1);
        send_rx(8'h55, 1'b1);
        wait_cycles(6);
        check("ovr_set", 32'(rx_overrun), 32'd1);
        check("ovr_head", 32'(uart_data), 32'h11);
        pulse_clr();
        check("ovr_clr", 32'(rx_overrun), 32'd0);

        // Pop on the same edge as a push into a full FIFO
        fork
            send_rx(8'h66, 1'b1);
            begin
                repeat (41) @(posedge clk);
                #1 uart_rd = 1'b1;
                @(posedge clk);
                #1 uart_rd = 1'b0;
            end
        join
        wait_cycles(4);
        check("simul_no_ovr", 32'(rx_overrun), 32'd0);
        exp_q[0] = 8'h22;
        exp_q[1] = 8'h33;
        exp_q[2] = 8'h44;
        exp_q[3] = 8'h66;
        for (int i = 0; i < 4; i++) begin
            check("simul_valid", 32'(uart_valid), 32'd1);
            check("simul_data", 32'(uart_data), 32'(exp_q[i]));
            read_rx();
        end
        check("simul_empty", 32'(uart_valid), 32'd0);

        // Loopback: TX and RX active together
        loop_en = 1'b1;
        wait_cycles(2);
        lb_q[0] = 8'h55;
        lb_q[1] = 8'hFF;
        lb_q[2] = 8'h00;
        for (int i = 0; i < 3; i++) write_tx(lb_q[i]);
        for (int i = 0; i < 3; i++) begin
            wait_valid("loop_valid");
            check("loop_data", 32'(uart_data), 32'(lb_q[i]));
            read_rx();
        end
        check("loop_flags", 32'({rx_overrun, rx_frame_err}), 32'd0);
        wait_cycles(10);
        loop_en = 1'b0;

        // Reset mid-frame in TX DATA and RX DATA
        for (int i = 0; i < 6; i++) write_tx(8'hF0);
        check("mid_ovf_pre", 32'(tx_overflow), 32'd1);
        fork
            send_rx(8'h0F, 1'b1);
            begin
                wait_cycles(14);
                resetq = 1'b0;
                #1;
                check("mid_rst_tx", 32'(tx), 32'd1);
                check("mid_rst_valid", 32'(uart_valid), 32'd0);
                check("mid_rst_data", 32'(uart_data), 32'h00);
                check("mid_rst_busy", 32'(tx_busy), 32'd0);
                check("mid_rst_flags", 32'({tx_overflow, rx_overrun, rx_frame_err}), 32'd0);
            end
        join
        resetq = 1'b1;
        wait_cycles(3);
        clear_mon();
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("post_rst_tx_quiet", 32'(lows), 32'd0);
        check("post_rst_valid", 32'(uart_valid), 32'd0);
        check("post_rst_busy", 32'(tx_busy), 32'd0);
        check("post_rst_frames", mon_data.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
